// File: rtl/alaw_pkg.sv
// Shared constants and state encoding for the A-law scheduler family.
package alaw_pkg;
  localparam int ALAW_LIN_W  = 13;
  localparam int ALAW_CODE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } alaw_state_e;
endpackage

// File: rtl/alaw_rr_arbiter.sv
// Combinational rotating-priority picker: searches upward from last+1, wrapping modulo NUM_CH.
module alaw_rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  always_comb begin
    int c;
    logic [CH_W-1:0] ci;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    ci    = '0;
    if (enable) begin
      for (int off = 1; off <= NUM_CH; off++) begin
        c = int'(last) + off;
        if (c >= NUM_CH) c = c - NUM_CH;
        ci = CH_W'(c);
        if (!any && req[ci]) begin
          any       = 1'b1;
          grant[ci] = 1'b1;
          idx       = ci;
        end
      end
    end
  end

endmodule

// File: rtl/alaw_rr_scheduler.sv
// Round-robin scheduler sharing one external alaw_coder among NUM_CH requesters.
// Define ALAW_RR_STATS_EN to add per-channel accepted-sample counters (stat_count, stat_clr).
module alaw_rr_scheduler
  import alaw_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*ALAW_LIN_W-1:0] in_lin,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [ALAW_LIN_W-1:0]        coder_lin,
  input  logic [ALAW_CODE_W-1:0]       coder_alaw,
  output logic                         out_valid,
  output logic [ALAW_CODE_W-1:0]       out_alaw,
  output logic [CH_W-1:0]              out_chan,
  input  logic                         out_ready,
`ifdef ALAW_RR_STATS_EN
  input  logic                         stat_clr,
  output logic [NUM_CH*16-1:0]         stat_count,
`endif
  output logic                         busy
);

  alaw_state_e            state_q, state_d;
  logic [CH_W-1:0]        last_q, last_d;
  logic                   out_valid_q, out_valid_d;
  logic [ALAW_CODE_W-1:0] out_alaw_q, out_alaw_d;
  logic [CH_W-1:0]        out_chan_q, out_chan_d;

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_any;
  logic              stage_free;

  assign stage_free = !out_valid_q || out_ready;

  alaw_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req    (in_valid),
    .last   (last_q),
    .enable ((state_q == ST_RUN) && en && stage_free),
    .grant  (grant),
    .idx    (grant_idx),
    .any    (grant_any)
  );

  assign in_ready = grant;

  always_comb begin
    coder_lin = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) coder_lin = in_lin[ALAW_LIN_W*i +: ALAW_LIN_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_alaw_d  = out_alaw_q;
    out_chan_d  = out_chan_q;

    if (grant_any) begin
      out_valid_d = 1'b1;
      out_alaw_d  = coder_alaw;
      out_chan_d  = grant_idx;
      last_d      = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = out_valid_q ? ST_DRAIN : ST_IDLE;
      // Completing the drain takes priority over a same-cycle re-enable.
      ST_DRAIN: begin
        if (out_valid_q && out_ready) state_d = ST_IDLE;
        else if (en)                  state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= CH_W'(NUM_CH - 1);
      out_valid_q <= 1'b0;
      out_alaw_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_alaw_q  <= out_alaw_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_alaw  = out_alaw_q;
  assign out_chan  = out_chan_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef ALAW_RR_STATS_EN
  logic [NUM_CH-1:0][15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (stat_clr) begin
      stat_d = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_valid[i] && grant[i]) stat_d[i] = stat_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_count = stat_q;
`endif

endmodule
